// File: rtl/edge_gen.sv
// Command-driven edge generator: a small FIFO of RISE/FALL/NOP/TOGGLE commands, each edge followed by a minimum hold.
// Define EDGE_GEN_PULSE_EN to turn op 11 into a timed PULSE (invert, hold cmd_len+1 cycles, restore, hold).
module edge_gen #(
    parameter int MIN_HOLD = 2,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_len,
    output logic       out,
    output logic       busy,
    output logic       done
);
    localparam int AW = $clog2(DEPTH);
`ifdef EDGE_GEN_PULSE_EN
    localparam int CW = 8;
    localparam int EW = 10;
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_PULSE} state_t;
`else
    localparam int CW = 4;
    localparam int EW = 2;
    typedef enum logic [1:0] {S_IDLE, S_HOLD} state_t;
`endif
    localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_HOLD - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_wr_data;
    logic [EW-1:0] w_head;
    logic [1:0]    w_head_op;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_out;
    logic          w_out_next;
    logic          r_done_pend;
    logic          w_done_pend_next;
    logic          r_done;

`ifdef EDGE_GEN_PULSE_EN
    logic [7:0]    w_head_len;
    logic [CW-1:0] w_pulse_last;
    assign w_wr_data    = {cmd_op, cmd_len};
    assign w_head_op    = w_head[9:8];
    assign w_head_len   = w_head[7:0];
    // Short pulses are stretched so the restore edge still respects the hold time.
    assign w_pulse_last = (w_head_len < HOLD_LAST) ? HOLD_LAST : w_head_len;
`else
    logic w_unused_len;
    assign w_unused_len = ^cmd_len;
    assign w_wr_data    = cmd_op;
    assign w_head_op    = w_head;
`endif

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full && !rst;
    // Head is read combinationally so a command can pop and execute on the same edge.
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_out_next       = r_out;
        w_done_pend_next = 1'b0;
        w_pop            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    case (w_head_op)
                        2'b01, 2'b10: begin
                            w_done_pend_next = 1'b1;
                            if (r_out != w_head_op[0]) begin
                                w_out_next   = w_head_op[0];
                                w_state_next = S_HOLD;
                                w_cnt_next   = HOLD_LAST;
                            end
                        end
                        2'b11: begin
                            w_out_next = !r_out;
`ifdef EDGE_GEN_PULSE_EN
                            w_state_next = S_PULSE;
                            w_cnt_next   = w_pulse_last;
`else
                            w_state_next     = S_HOLD;
                            w_cnt_next       = HOLD_LAST;
                            w_done_pend_next = 1'b1;
`endif
                        end
                        default: w_done_pend_next = 1'b1;
                    endcase
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
`ifdef EDGE_GEN_PULSE_EN
            S_PULSE: begin
                if (r_cnt == '0) begin
                    w_out_next       = !r_out;
                    w_state_next     = S_HOLD;
                    w_cnt_next       = HOLD_LAST;
                    w_done_pend_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out       <= 1'b0;
            r_done_pend <= 1'b0;
            r_done      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_out       <= w_out_next;
            r_done_pend <= w_done_pend_next;
            r_done      <= r_done_pend;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    assign out  = r_out;
    assign done = r_done;
    assign busy = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_edge_gen.sv
// Self-checking bench for edge_gen: directed scenarios plus randomized traffic against a timeline reference model.
// Honours EDGE_GEN_PULSE_EN the same way as the design.
module tb_edge_gen;
    localparam int M_HOLD = 2;
    localparam int DEP    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_len = 8'd0;
    logic       out;
    logic       busy;
    logic       done;

    edge_gen #(.MIN_HOLD(M_HOLD), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .out(out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] len;
    } cmd_t;

    // Reference model: command queue plus absolute edge numbers of future events.
    cmd_t q[$];
    int   cyc        = 0;
    int   ready_at   = 0;
    int   done_at    = -1;
    int   restore_at = -1;
    bit   m_out = 0, m_done = 0, m_busy = 0, m_ready = 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [1:0] op,
                              input logic [7:0] len, output bit acc);
        int   sz;
        int   w;
        cmd_t c;
        acc = 0;
        cyc++;
        if (r) begin
            q.delete();
            m_out = 0; m_done = 0; m_busy = 0; m_ready = 1;
            ready_at = 0; done_at = -1; restore_at = -1;
            return;
        end
        m_done = (cyc == done_at);
        sz = q.size();
        if (cyc == restore_at) m_out = ~m_out;
        if (sz > 0 && cyc >= ready_at) begin
            c = q.pop_front();
            done_at  = cyc + 1;
            ready_at = cyc + 1;
            if (c.op == 2'b01 || c.op == 2'b10) begin
                if (m_out != (c.op == 2'b01)) begin
                    m_out    = (c.op == 2'b01);
                    ready_at = cyc + M_HOLD + 1;
                end
            end else if (c.op == 2'b11) begin
                m_out = ~m_out;
`ifdef EDGE_GEN_PULSE_EN
                w = int'(c.len) + 1;
                if (w < M_HOLD) w = M_HOLD;
                restore_at = cyc + w;
                done_at    = cyc + w + 1;
                ready_at   = cyc + w + M_HOLD + 1;
`else
                w = 0;
                ready_at = cyc + M_HOLD + 1;
`endif
            end
        end
        if (v && sz < DEP) begin
            c.op = op;
            c.len = len;
            q.push_back(c);
            acc = 1;
            $display("edge %0d accept op=%0d len=%0d", cyc, op, len);
        end
        m_busy  = (q.size() > 0) || (cyc < ready_at - 1);
        m_ready = (q.size() < DEP);
    endtask

    task automatic cycle(input bit r, input bit v, input logic [1:0] op,
                         input logic [7:0] len, output bit acc);
        rst = r; cmd_valid = v; cmd_op = op; cmd_len = len;
        @(posedge clk);
        model_edge(r, v, op, len, acc);
        #1;
        check_val("out", {31'd0, out}, {31'd0, m_out});
        check_val("done", {31'd0, done}, {31'd0, m_done});
        check_val("busy", {31'd0, busy}, {31'd0, m_busy});
        check_val("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_ready});
    endtask

    initial begin
        bit   acc;
        bit   prev;
        bit   saw_full;
        int   edges[$];
        int   n_done;
        int   k;
        int   ones;
        bit   r;
        bit   v;
        logic [1:0] op;
        logic [7:0] len;

        // Reset, RISE accepted at edge 3, edge at 4, done at 5, idle after hold.
        cycle(1, 0, 2'b00, 8'd0, acc);
        cycle(1, 0, 2'b00, 8'd0, acc);
        check_val("rst_out", {31'd0, out}, 32'd0);
        check_val("rst_ready", {31'd0, cmd_ready}, 32'd1);
        cycle(0, 1, 2'b01, 8'd0, acc);
        check_val("r029_acc_out", {31'd0, out}, 32'd0);
        cycle(0, 0, 2'b00, 8'd0, acc);
        check_val("r029_out_e4", {31'd0, out}, 32'd1);
        cycle(0, 0, 2'b00, 8'd0, acc);
        check_val("r029_done_e5", {31'd0, done}, 32'd1);
        cycle(0, 0, 2'b00, 8'd0, acc);
        check_val("r029_busy_e6", {31'd0, busy}, 32'd0);

        // RISE while already high: no edge, no hold, done still pulses.
        cycle(0, 1, 2'b01, 8'd0, acc);
        cycle(0, 0, 2'b00, 8'd0, acc);
        check_val("r032_out", {31'd0, out}, 32'd1);
        check_val("r032_busy", {31'd0, busy}, 32'd0);
        cycle(0, 0, 2'b00, 8'd0, acc);
        check_val("r032_done", {31'd0, done}, 32'd1);

        // Back-to-back RISE, FALL, RISE: edges MIN_HOLD+1 apart, three dones.
        cycle(1, 0, 2'b00, 8'd0, acc);
        prev = out;
        n_done = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 0)      cycle(0, 1, 2'b01, 8'd0, acc);
            else if (i == 1) cycle(0, 1, 2'b10, 8'd0, acc);
            else if (i == 2) cycle(0, 1, 2'b01, 8'd0, acc);
            else             cycle(0, 0, 2'b00, 8'd0, acc);
            if (out !== prev) edges.push_back(cyc);
            prev = out;
            if (done === 1'b1) n_done++;
        end
        check_val("r030_edges", edges.size(), 32'd3);
        check_val("r030_dones", n_done, 32'd3);
        if (edges.size() == 3) begin
            check_val("r030_gap1", edges[1] - edges[0], M_HOLD + 1);
            check_val("r030_gap2", edges[2] - edges[1], M_HOLD + 1);
        end

        // Overfill the FIFO while the line is held: ready drops, nothing lost.
        cycle(1, 0, 2'b00, 8'd0, acc);
        k = 0;
        saw_full = 0;
        for (int i = 0; i < 30; i++) begin
            if (k < 8) cycle(0, 1, (k % 2 == 0) ? 2'b01 : 2'b10, 8'd0, acc);
            else       cycle(0, 0, 2'b00, 8'd0, acc);
            if (acc) k++;
            if (cmd_ready === 1'b0) saw_full = 1;
        end
        check_val("r031_full_seen", {31'd0, saw_full}, 32'd1);
        check_val("r031_accepted", k, 32'd8);

        // op 11 with cmd_len=4 from out=0.
        cycle(1, 0, 2'b00, 8'd0, acc);
        cycle(0, 1, 2'b11, 8'd4, acc);
        ones = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 2'b00, 8'd0, acc);
            if (out === 1'b1) ones++;
        end
`ifdef EDGE_GEN_PULSE_EN
        check_val("r033_high_cycles", ones, 32'd5);
`else
        check_val("r033_high_cycles", ones, 32'd12);
`endif

        // Reset two cycles into a long op 11, with a command presented during reset.
        cycle(1, 0, 2'b00, 8'd0, acc);
        cycle(0, 1, 2'b11, 8'd8, acc);
        cycle(0, 0, 2'b00, 8'd0, acc);
        cycle(0, 0, 2'b00, 8'd0, acc);
        cycle(1, 1, 2'b01, 8'd0, acc);
        check_val("r034_out", {31'd0, out}, 32'd0);
        check_val("r034_done", {31'd0, done}, 32'd0);
        check_val("r034_busy", {31'd0, busy}, 32'd0);
        check_val("r034_ready", {31'd0, cmd_ready}, 32'd1);
        cycle(0, 0, 2'b00, 8'd0, acc);
        check_val("r034_done_after", {31'd0, done}, 32'd0);
        check_val("r034_busy_after", {31'd0, busy}, 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            r   = ($urandom_range(0, 149) == 0);
            v   = 1'($urandom_range(0, 1));
            op  = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                              : 8'($urandom_range(0, 6));
            cycle(r, v, op, len, acc);
        end
        for (int i = 0; i < 80; i++) cycle(0, 0, 2'b00, 8'd0, acc);
        check_val("final_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
